// File: rtl/router_ctrl.sv
// router_ctrl: packet-loading sequencer for a 1x3 router.
// Decodes the header address, drives one-hot FIFO write enables, stalls the
// source while the target FIFO is busy or full, and issues per-channel soft
// resets to FIFOs that hold data nobody reads.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] fifo_full,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic [2:0] valid_out,
  output logic [2:0] soft_reset,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,  // decode address
    LFD = 3'd1,  // load first data (header write)
    LD  = 3'd2,  // load payload
    FFS = 3'd3,  // target FIFO full, hold
    LAF = 3'd4,  // load after full (replay the blocked byte)
    LP  = 3'd5,  // load parity byte
    CPE = 3'd6,  // check parity error
    WTE = 3'd7   // wait until target FIFO drains
  } state_t;

  // Terminal count of the idle counters; TIMEOUT is limited to 2..31 so it fits.
  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Flag vectors padded to four entries so that a 2-bit index is always in
  // range. Address 3 never leaves DA, so the padding bit is never consulted
  // for a live packet.
  logic [3:0] full_ext;
  logic [3:0] empty_ext;
  logic [3:0] soft_reset_ext;

  logic sel_full;
  logic sel_empty;
  logic sel_soft_reset;
  logic hdr_valid;
  logic hdr_empty;

  assign full_ext       = {1'b0, fifo_full};
  assign empty_ext      = {1'b0, fifo_empty};
  assign soft_reset_ext = {1'b0, soft_reset};

  assign sel_full       = full_ext[addr_q];
  assign sel_empty      = empty_ext[addr_q];
  assign sel_soft_reset = soft_reset_ext[addr_q];
  assign hdr_valid      = (data_in != 2'd3);
  assign hdr_empty      = empty_ext[data_in];

  // State and latched destination address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; a soft reset of the active channel overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    // The address is captured on any valid header cycle, even an invalid
    // address, because the FSM stays in DA in that case and never uses it.
    if (state_q == DA && pkt_valid) begin
      addr_d = data_in;
    end

    if (state_q != DA && sel_soft_reset) begin
      state_d = DA;
    end else begin
      case (state_q)
        DA: begin
          if (pkt_valid && hdr_valid) begin
            state_d = hdr_empty ? LFD : WTE;
          end
        end
        LFD: state_d = LD;
        LD: begin
          if (sel_full) begin
            state_d = FFS;
          end else if (!pkt_valid) begin
            state_d = LP;
          end
        end
        FFS: begin
          if (!sel_full) begin
            state_d = LAF;
          end
        end
        LAF: begin
          if (parity_done) begin
            state_d = DA;
          end else if (low_pkt_valid) begin
            state_d = LP;
          end else begin
            state_d = LD;
          end
        end
        LP:  state_d = CPE;
        CPE: state_d = sel_full ? FFS : DA;
        WTE: begin
          if (sel_empty) begin
            state_d = LFD;
          end
        end
        default: state_d = DA;
      endcase
    end
  end

  // Moore decodes consumed by the register block and the source.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b0;
    case (state_q)
      DA: detect_add = 1'b1;
      LFD: begin
        lfd_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FFS: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LP: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      CPE: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      WTE: busy = 1'b1;
      default: detect_add = 1'b0;
    endcase
  end

  // Per-channel write steering, data-available flags and idle timeout.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [4:0] cnt_q, cnt_d;
    logic       soft_reset_q, soft_reset_d;

    assign write_enb[gi]  = write_enb_reg && (addr_q == 2'(gi));
    assign valid_out[gi]  = ~fifo_empty[gi];
    assign soft_reset[gi] = soft_reset_q;

    // Count consecutive cycles with data waiting and no read; a pulse ends the run.
    always_comb begin
      cnt_d        = cnt_q + 5'd1;
      soft_reset_d = 1'b0;
      if (!valid_out[gi] || read_enb[gi]) begin
        cnt_d = 5'd0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d        = 5'd0;
        soft_reset_d = 1'b1;
      end
    end

    // Idle counter and soft-reset pulse registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q        <= 5'd0;
        soft_reset_q <= 1'b0;
      end else begin
        cnt_q        <= cnt_d;
        soft_reset_q <= soft_reset_d;
      end
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the router control block.
module tb_router_ctrl;

  localparam int TIMEOUT = 30;

  // Decode vector layout: {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] D_DA  = 8'b1000_0000;
  localparam logic [7:0] D_LFD = 8'b0100_0011;
  localparam logic [7:0] D_LD  = 8'b0010_0010;
  localparam logic [7:0] D_LAF = 8'b0001_0011;
  localparam logic [7:0] D_FFS = 8'b0000_1001;
  localparam logic [7:0] D_LP  = 8'b0000_0011;
  localparam logic [7:0] D_CPE = 8'b0000_0101;
  localparam logic [7:0] D_WTE = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] fifo_empty;
  logic [2:0] fifo_full;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic [2:0] valid_out;
  logic [2:0] soft_reset;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [7:0] dec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .read_enb      (read_enb),
    .write_enb     (write_enb),
    .valid_out     (valid_out),
    .soft_reset    (soft_reset),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  assign dec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Phases of a packet as named by the protocol; numbering is arbitrary.
  localparam int P_IDLE = 0, P_HDR = 1, P_BODY = 2, P_STALL = 3,
                 P_REPLAY = 4, P_PAR = 5, P_CHECK = 6, P_WAIT = 7;

  int         m_phase;
  int         m_addr;
  int         run_len [3];   // consecutive unread cycles with data waiting
  logic [2:0] m_sr;

  function automatic logic [7:0] dec_of(input int ph);
    case (ph)
      P_IDLE:   return D_DA;
      P_HDR:    return D_LFD;
      P_BODY:   return D_LD;
      P_STALL:  return D_FFS;
      P_REPLAY: return D_LAF;
      P_PAR:    return D_LP;
      P_CHECK:  return D_CPE;
      default:  return D_WTE;
    endcase
  endfunction

  function automatic logic [2:0] we_of(input int ph, input int a);
    logic writing;
    writing = (ph == P_HDR) || (ph == P_BODY) || (ph == P_PAR) || (ph == P_REPLAY);
    if (writing && a < 3) return 3'(1 << a);
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_addr  = 0;
    foreach (run_len[i]) run_len[i] = 0;
    m_sr = 3'b000;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int   nxt;
    logic tgt_full, tgt_empty, tgt_kill;
    nxt       = m_phase;
    tgt_full  = (m_addr < 3) ? fifo_full[m_addr]  : 1'b0;
    tgt_empty = (m_addr < 3) ? fifo_empty[m_addr] : 1'b0;
    tgt_kill  = (m_addr < 3) ? m_sr[m_addr]       : 1'b0;
    if (m_phase != P_IDLE && tgt_kill) begin
      nxt = P_IDLE;
    end else if (m_phase == P_IDLE) begin
      if (pkt_valid && data_in != 2'd3)
        nxt = fifo_empty[data_in] ? P_HDR : P_WAIT;
    end else if (m_phase == P_HDR) begin
      nxt = P_BODY;
    end else if (m_phase == P_BODY) begin
      if (tgt_full) nxt = P_STALL;
      else if (!pkt_valid) nxt = P_PAR;
    end else if (m_phase == P_STALL) begin
      if (!tgt_full) nxt = P_REPLAY;
    end else if (m_phase == P_REPLAY) begin
      nxt = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
    end else if (m_phase == P_PAR) begin
      nxt = P_CHECK;
    end else if (m_phase == P_CHECK) begin
      nxt = tgt_full ? P_STALL : P_IDLE;
    end else begin
      if (tgt_empty) nxt = P_HDR;
    end
    if (m_phase == P_IDLE && pkt_valid) m_addr = int'(data_in);
    for (int i = 0; i < 3; i++) begin
      if (!fifo_empty[i] && !read_enb[i]) run_len[i]++;
      else run_len[i] = 0;
      m_sr[i] = (run_len[i] > 0) && (run_len[i] % TIMEOUT == 0);
    end
    m_phase = nxt;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       pd;
    logic       lpv;
    logic [2:0] fe;
    logic [2:0] ff;
    logic [2:0] re;
    logic [7:0] dec;
    logic [2:0] we;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pv, input logic [1:0] din, input logic pd,
                              input logic lpv, input logic [2:0] fe, input logic [2:0] ff,
                              input logic [2:0] re, input logic [7:0] d, input logic [2:0] we);
    vec_t v;
    v.pv = pv; v.din = din; v.pd = pd; v.lpv = lpv;
    v.fe = fe; v.ff = ff; v.re = re; v.dec = d; v.we = we;
    return v;
  endfunction

  task automatic idle_inputs();
    pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_empty = 3'b111; fifo_full = 3'b000; read_enb = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] vo_exp;
    int we_cnt, rst_cnt, ld_cnt, ld_busy, seen_at;

    // ---- reset state ----
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_dec", 16'(dec), 16'(D_DA));
    chk("reset_we", 16'(write_enb), 16'd0);
    chk("reset_sr", 16'(soft_reset), 16'd0);
    fifo_empty = 3'b010;
    #1;
    chk("reset_valid_out", 16'(valid_out), 16'h5);
    fifo_empty = 3'b111;
    #1;
    reset = 1'b0;
    tick();
    $display("reset sequence done");

    // ---- table ----
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 3, 0, 0, 7, 0, 0, D_DA, 0));
    // channel 1, short packet
    vecs.push_back(mk(1, 1, 0, 0, 7, 0, 0, D_LFD, 3'b010));
    vecs.push_back(mk(1, 0, 0, 0, 7, 0, 0, D_LD,  3'b010));
    vecs.push_back(mk(1, 2, 0, 0, 7, 0, 0, D_LD,  3'b010));
    vecs.push_back(mk(1, 3, 0, 0, 7, 0, 0, D_LD,  3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_LP,  3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_CPE, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_DA,  3'b000));
    // channel 2 busy: WTE, then full during CPE, then LAF with parity_done
    vecs.push_back(mk(1, 2, 0, 0, 3'b011, 0, 4, D_WTE, 0));
    vecs.push_back(mk(1, 2, 0, 0, 3'b011, 0, 4, D_WTE, 0));
    vecs.push_back(mk(1, 2, 0, 0, 7, 0, 4, D_LFD, 3'b100));
    vecs.push_back(mk(1, 0, 0, 0, 7, 0, 4, D_LD,  3'b100));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 4, D_LP,  3'b100));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 4, D_CPE, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 7, 3'b100, 4, D_FFS, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 3'b100, 4, D_FFS, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 4, D_LAF, 3'b100));
    vecs.push_back(mk(0, 0, 1, 1, 7, 0, 4, D_DA,  0));
    // channel 0 full for four cycles in LD, LAF falls back to LD
    vecs.push_back(mk(1, 0, 0, 0, 7, 0, 0, D_LFD, 3'b001));
    vecs.push_back(mk(1, 0, 0, 0, 7, 0, 0, D_LD,  3'b001));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 0, 0, 7, 1, 0, D_FFS, 0));
    vecs.push_back(mk(1, 0, 0, 0, 7, 0, 0, D_LAF, 3'b001));
    vecs.push_back(mk(1, 0, 0, 0, 7, 0, 0, D_LD,  3'b001));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_LP,  3'b001));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_CPE, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_DA,  0));
    // channel 1: other channels full are ignored; LAF with low_pkt_valid -> LP
    vecs.push_back(mk(1, 1, 0, 0, 7, 3'b101, 0, D_LFD, 3'b010));
    vecs.push_back(mk(1, 1, 0, 0, 7, 3'b101, 0, D_LD,  3'b010));
    vecs.push_back(mk(1, 1, 0, 0, 7, 3'b101, 0, D_LD,  3'b010));
    vecs.push_back(mk(1, 1, 0, 0, 7, 3'b010, 0, D_FFS, 0));
    vecs.push_back(mk(1, 1, 0, 0, 7, 0, 0, D_LAF, 3'b010));
    vecs.push_back(mk(0, 0, 0, 1, 7, 0, 0, D_LP,  3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_CPE, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, D_DA,  0));

    foreach (vecs[k]) begin
      pkt_valid = vecs[k].pv; data_in = vecs[k].din; parity_done = vecs[k].pd;
      low_pkt_valid = vecs[k].lpv; fifo_empty = vecs[k].fe; fifo_full = vecs[k].ff;
      read_enb = vecs[k].re;
      tick();
      vo_exp = ~vecs[k].fe;
      chk($sformatf("vec%0d_dec", k), 16'(dec), 16'(vecs[k].dec));
      chk($sformatf("vec%0d_we", k), 16'(write_enb), 16'(vecs[k].we));
      chk($sformatf("vec%0d_valid_out", k), 16'(valid_out), 16'(vo_exp));
      $display("vec %0d dec=%b we=%b", k, dec, write_enb);
    end

    // ---- ten-byte packet to channel 1 ----
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd1;
    tick();
    chk("p10_lfd", 16'(lfd_state), 16'd1);
    we_cnt = 0; rst_cnt = 0; ld_cnt = 0; ld_busy = 0;
    for (int c = 0; c < 16; c++) begin
      if (write_enb == 3'b010) we_cnt++;
      if (rst_int_reg) rst_cnt++;
      if (ld_state) ld_cnt++;
      if (ld_state && busy) ld_busy++;
      pkt_valid = (c < 10);
      data_in   = 2'(c);
      tick();
    end
    chk("p10_we_cycles", 16'(we_cnt), 16'd12);
    chk("p10_rst_int", 16'(rst_cnt), 16'd1);
    chk("p10_ld_cycles", 16'(ld_cnt), 16'd10);
    chk("p10_ld_busy", 16'(ld_busy), 16'd0);
    chk("p10_end_da", 16'(dec), 16'(D_DA));
    $display("ten-byte packet we_cycles=%0d ld_cycles=%0d", we_cnt, ld_cnt);

    // ---- timeout, no reads ----
    idle_inputs();
    tick();
    fifo_empty = 3'b101;
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk($sformatf("to_edge%0d", e), 16'(soft_reset), (e == 30) ? 16'h2 : 16'h0);
    end
    $display("timeout without reads done");

    // ---- timeout restarted by a read pulse at cycle 20 ----
    fifo_empty = 3'b111;
    tick();
    fifo_empty = 3'b101;
    for (int c = 1; c <= 51; c++) begin
      read_enb = (c == 20) ? 3'b010 : 3'b000;
      tick();
      chk($sformatf("tor_cycle%0d", c), 16'(soft_reset[1]), (c == 50) ? 16'd1 : 16'd0);
    end
    $display("timeout with read pulse done");

    // ---- asynchronous reset in LD ----
    idle_inputs();
    tick();
    pkt_valid = 1'b1; data_in = 2'd0;
    tick();
    tick();
    chk("ar_ld", 16'(ld_state), 16'd1);
    chk("ar_we_before", 16'(write_enb), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_we_after", 16'(write_enb), 16'd0);
    chk("ar_da_after", 16'(detect_add), 16'd1);
    pkt_valid = 1'b0;
    tick();
    chk("ar_held_da", 16'(dec), 16'(D_DA));
    reset = 1'b0;
    tick();
    $display("async reset in LD done");

    // ---- soft reset of the active channel while in FFS ----
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd0;
    tick();
    tick();
    pkt_valid = 1'b0; fifo_full = 3'b001; fifo_empty = 3'b110;
    tick();
    chk("sr_ffs", 16'(full_state), 16'd1);
    seen_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (soft_reset[0]) begin
        seen_at = i;
        chk("sr_still_ffs", 16'(full_state), 16'd1);
        tick();
        chk("sr_back_da", 16'(dec), 16'(D_DA));
        break;
      end
    end
    chk("sr_pulse_cycle", 16'(seen_at), 16'd29);
    $display("soft reset during FFS seen at %0d", seen_at);

    // ---- randomized run against the model ----
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] flip;
      pkt_valid     = ($urandom_range(0, 9) < 7);
      data_in       = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 5) == 0);
      low_pkt_valid = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < 3; b++) begin
        flip[b] = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 7) == 0) fifo_full[b] = ~fifo_full[b];
        read_enb[b] = ($urandom_range(0, 79) == 0);
      end
      fifo_empty = fifo_empty ^ flip;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        model_step();
      end
      tick();
      vo_exp = ~fifo_empty;
      chk($sformatf("rnd%0d_dec", n), 16'(dec), 16'(dec_of(m_phase)));
      chk($sformatf("rnd%0d_we", n), 16'(write_enb), 16'(we_of(m_phase, m_addr)));
      chk($sformatf("rnd%0d_sr", n), 16'(soft_reset), 16'(m_sr));
      chk($sformatf("rnd%0d_valid_out", n), 16'(valid_out), 16'(vo_exp));
      $display("rnd %0d phase=%0d dec=%b we=%b sr=%b", n, m_phase, dec, write_enb, soft_reset);
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
